// File: rtl/seven_segment_scan_controller.sv
// Eight-digit multiplexed 7-segment scan controller with a double-buffered display register.
// Optional leading-zero suppression when SEVEN_SEG_LEADING_ZERO_BLANK_EN is defined.
module seven_segment_scan_controller #(
  parameter int DIGIT_CYCLES = 32768,
  parameter int BLANK_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_mask,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  digit_en,
  output logic [7:0]  an_outputs,
  output logic [6:0]  seg_outputs,
  output logic        dp_output,
  output logic        frame_tick
);

  localparam int            CW        = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count;
  logic [2:0]    idx;
  logic          slot_last, frame_last;

  assign slot_last  = (count == SLOT_LAST);
  assign frame_last = slot_last && (idx == 3'd7);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      idx   <= '0;
    end else if (slot_last) begin
      count <= '0;
      idx   <= idx + 3'd1;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Write path: shadow collects masked writes, display only changes at the frame boundary.
  logic        pending, accept, commit;
  logic [31:0] shadow, display, merged;
  logic [7:0]  shadow_dp, display_dp, merged_dp;

  assign wr_ready = !pending;
  assign accept   = wr_valid && !pending;
  assign commit   = frame_tick && pending;

  // NOTE: every always_comb output gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    merged    = shadow;
    merged_dp = shadow_dp;
    for (int k = 0; k < 8; k++) begin
      if (wr_mask[k]) begin
        merged[4*k +: 4] = wr_data[4*k +: 4];
        merged_dp[k]     = wr_dp[k];
      end
    end
  end

  // NOTE: the nibble stores are plain flops with a defined reset so the display starts blank-zero,
  // unlike RAM-style arrays which are normally left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow     <= '0;
      shadow_dp  <= '0;
      display    <= '0;
      display_dp <= '0;
      pending    <= 1'b0;
    end else if (accept) begin
      shadow    <= merged;
      shadow_dp <= merged_dp;
      pending   <= 1'b1;
    end else if (commit) begin
      display    <= shadow;
      display_dp <= shadow_dp;
      pending    <= 1'b0;
    end
  end

  logic [7:0] supp;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [7:0] lz, lz_next;
  logic [7:1] upper_zero;

  always_comb begin
    upper_zero    = '0;
    lz_next       = '0;
    upper_zero[7] = (shadow[31:28] == 4'h0);
    for (int k = 6; k >= 1; k--) begin
      upper_zero[k] = upper_zero[k+1] && (shadow[4*k +: 4] == 4'h0);
    end
    for (int k = 1; k < 8; k++) begin
      lz_next[k] = upper_zero[k] && !shadow_dp[k];
    end
  end

  // Reset value matches the all-zero display: digits 1..7 are leading zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lz <= 8'hFE;
    end else if (commit) begin
      lz <= lz_next;
    end
  end

  assign supp = lz;
`else
  assign supp = '0;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic       lit_q, lit_d;
  logic [3:0] cur_nibble;
  logic [7:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign cur_nibble = display[{idx, 2'b00} +: 4];

  // Pin state is computed from count/idx and registered, so pins lag the counter by one cycle.
  always_comb begin
    state_d = (count >= BLANK_END) ? ST_DRIVE : ST_BLANK;
    lit_d   = lit_q;
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (state_d == ST_DRIVE && state_q == ST_BLANK) begin
      lit_d = digit_en[idx] && !supp[idx];
    end
    if (state_d == ST_DRIVE && lit_d) begin
      an_d  = ~(8'd1 << idx);
      seg_d = seg_decode(cur_nibble);
      dp_d  = ~display_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BLANK;
      lit_q       <= 1'b0;
      an_outputs  <= 8'hFF;
      seg_outputs <= 7'h7F;
      dp_output   <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lit_q       <= lit_d;
      an_outputs  <= an_d;
      seg_outputs <= seg_d;
      dp_output   <= dp_d;
      frame_tick  <= frame_last;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Self-checking bench for seven_segment_scan_controller: positional reference model plus
// table-driven and hand-written sequences. Model honours SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module tb_seven_segment_scan_controller;

  localparam int DC    = 16;
  localparam int BC    = 2;
  localparam int FRAME = DC * 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic [7:0]  wr_dp = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  an_outputs;
  logic [6:0]  seg_outputs;
  logic        dp_output;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  seven_segment_scan_controller #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .wr_dp       (wr_dp),
    .digit_en    (digit_en),
    .an_outputs  (an_outputs),
    .seg_outputs (seg_outputs),
    .dp_output   (dp_output),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame is derived from the number of edges since reset release.
  logic [3:0] m_disp[8];
  logic [3:0] m_sh[8];
  logic [7:0] m_disp_dp, m_sh_dp;
  logic       m_pend, m_acc, m_lit;
  int         m_n;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_ft, e_rdy;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic suppressed(input int k);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (k == 0) return 1'b0;
    for (int j = k; j < 8; j++) if (m_disp[j] != 4'h0) return 1'b0;
    return !m_disp_dp[k];
`else
    return (k < 0);
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_disp[k] = '0;
      m_sh[k]   = '0;
    end
    m_disp_dp = '0;
    m_sh_dp   = '0;
    m_pend    = 1'b0;
    m_acc     = 1'b0;
    m_lit     = 1'b0;
    m_n       = 0;
  endtask

  task automatic model_step();
    int   q, c, d;
    logic ft_pre, acc, com;
    m_n++;
    q      = m_n - 1;
    ft_pre = (m_n >= 2) && (((m_n - 2) % FRAME) == FRAME - 1);
    acc    = wr_valid && !m_pend;
    com    = ft_pre && m_pend;
    if (acc) begin
      for (int k = 0; k < 8; k++) begin
        if (wr_mask[k]) begin
          m_sh[k]    = wr_data[4*k +: 4];
          m_sh_dp[k] = wr_dp[k];
        end
      end
      m_pend = 1'b1;
    end
    if (com) begin
      for (int k = 0; k < 8; k++) m_disp[k] = m_sh[k];
      m_disp_dp = m_sh_dp;
      m_pend    = 1'b0;
    end
    m_acc = acc;
    c = q % DC;
    d = (q / DC) % 8;
    if (c == BC) m_lit = digit_en[d] && !suppressed(d);
    if (c >= BC && m_lit) begin
      e_an  = ~(8'd1 << d);
      e_seg = seg_of(m_disp[d]);
      e_dp  = ~m_disp_dp[d];
    end else begin
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end
    e_ft  = ((q % FRAME) == FRAME - 1);
    e_rdy = !m_pend;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle", {14'd0, an_outputs, seg_outputs, dp_output, frame_tick, wr_ready},
          {14'd0, e_an, e_seg, e_dp, e_ft, e_rdy});
  endtask

  task automatic do_write(input logic [31:0] data, input logic [7:0] mask, input logic [7:0] dp);
    wr_valid = 1'b1;
    wr_data  = data;
    wr_mask  = mask;
    wr_dp    = dp;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (m_acc) break;
    end
    check("write_accepted", {31'd0, m_acc}, 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_commit();
    for (int i = 0; i < 400 && m_pend; i++) tick();
    check("commit_done", {31'd0, m_pend}, 32'd0);
  endtask

  task automatic run_to(input int slot, input int cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      found = (((m_n - 1) / DC) % 8 == slot) && ((m_n - 1) % DC == cyc);
    end
    check("run_to_reached", {31'd0, found}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [7:0]  mask;
    logic [7:0]  dp;
    logic [7:0]  en;
    int          digit;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic       ft_prev, ft_prev2, rdy_prev;
    logic [7:0] lit_mask;
    int         lit_cycles, ft_count;

    vecs[0] = '{32'h1234_5678, 8'hFF, 8'h00, 8'hFF, 7, 8'h7F, 7'h79, 1'b1};
    vecs[1] = '{32'h0000_000F, 8'h01, 8'h01, 8'hFF, 0, 8'hFE, 7'h0E, 1'b0};
    vecs[2] = '{32'h0000_0000, 8'h00, 8'h00, 8'hFF, 1, 8'hFD, 7'h78, 1'b1};
    vecs[3] = '{32'hA000_0000, 8'h80, 8'h00, 8'hFF, 7, 8'h7F, 7'h08, 1'b1};
    vecs[4] = '{32'h0000_0800, 8'h04, 8'h00, 8'hFF, 2, 8'hFB, 7'h00, 1'b1};
    vecs[5] = '{32'h0000_0000, 8'h00, 8'h00, 8'hFB, 2, 8'hFF, 7'h7F, 1'b1};
    vecs[6] = '{32'h000C_0000, 8'h10, 8'h00, 8'hFF, 4, 8'hEF, 7'h46, 1'b1};
    vecs[7] = '{32'h00E0_0000, 8'h20, 8'h20, 8'hFF, 5, 8'hDF, 7'h06, 1'b0};

    // Reset state while reset_n is held low.
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_an", {24'd0, an_outputs}, 32'hFF);
    check("rst_seg", {25'd0, seg_outputs}, 32'h7F);
    check("rst_dp", {31'd0, dp_output}, 32'd1);
    check("rst_ft", {31'd0, frame_tick}, 32'd0);
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    reset_n = 1'b1;

    // Table-driven writes, each checked mid-DRIVE of the chosen digit in the frame after commit.
    foreach (vecs[i]) begin
      digit_en = vecs[i].en;
      do_write(vecs[i].data, vecs[i].mask, vecs[i].dp);
      wait_commit();
      run_to(vecs[i].digit, 8);
      check($sformatf("vec%0d_an", i), {24'd0, an_outputs}, {24'd0, vecs[i].an});
      check($sformatf("vec%0d_seg", i), {25'd0, seg_outputs}, {25'd0, vecs[i].seg});
      check($sformatf("vec%0d_dp", i), {31'd0, dp_output}, {31'd0, vecs[i].dpo});
    end
    digit_en = 8'hFF;

    // Back-to-back writes: B waits until the cycle after frame_tick.
    do_write(32'h1111_1111, 8'hFF, 8'h00);
    wr_valid = 1'b1;
    wr_data  = 32'h2222_2222;
    wr_mask  = 8'hFF;
    wr_dp    = 8'h00;
    ft_prev  = frame_tick;
    ft_prev2 = 1'b0;
    rdy_prev = wr_ready;
    for (int i = 0; i < 400; i++) begin
      ft_prev2 = ft_prev;
      ft_prev  = frame_tick;
      rdy_prev = wr_ready;
      tick();
      if (m_acc) break;
    end
    wr_valid = 1'b0;
    check("b_accepted", {31'd0, m_acc}, 32'd1);
    check("b_ready_at_accept", {31'd0, rdy_prev}, 32'd1);
    check("b_after_tick", {31'd0, ft_prev2}, 32'd1);
    run_to(0, 8);
    check("a_shown_first", {25'd0, seg_outputs}, 32'h79);
    wait_commit();
    run_to(0, 8);
    check("b_shown_next", {25'd0, seg_outputs}, 32'h24);

    // All digits disabled: dark for two frames, timing and commit unaffected.
    digit_en = 8'h00;
    do_write(32'h3333_3333, 8'hFF, 8'h00);
    repeat (DC) tick();
    lit_cycles = 0;
    ft_count   = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (an_outputs != 8'hFF) lit_cycles++;
      if (frame_tick) ft_count++;
    end
    check("dark_lit_cycles", lit_cycles, 0);
    check("dark_frame_ticks", ft_count, 2);
    check("dark_commit_ready", {31'd0, wr_ready}, 32'd1);
    digit_en = 8'hFF;

    // Leading zeros: which anodes ever go low over one full frame.
    for (int pass = 0; pass < 2; pass++) begin
      do_write(32'h0000_0050, 8'hFF, (pass == 0) ? 8'h00 : 8'h20);
      wait_commit();
      lit_mask = '0;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        lit_mask = lit_mask | ~an_outputs;
      end
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      check($sformatf("lz_mask_pass%0d", pass), {24'd0, lit_mask},
            (pass == 0) ? 32'h03 : 32'h23);
`else
      check($sformatf("lz_mask_pass%0d", pass), {24'd0, lit_mask}, 32'hFF);
`endif
    end

    // Reset mid-DRIVE with a pending write: outputs go dark at once, update is discarded.
    do_write(32'h9999_9999, 8'hFF, 8'h00);
    run_to(3, 8);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_an", {24'd0, an_outputs}, 32'hFF);
    check("mid_rst_seg", {25'd0, seg_outputs}, 32'h7F);
    check("mid_rst_dp", {31'd0, dp_output}, 32'd1);
    check("mid_rst_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    tick();
    check("post_rst_blank", {24'd0, an_outputs}, 32'hFF);
    run_to(0, 8);
    check("post_rst_d0_an", {24'd0, an_outputs}, 32'hFE);
    check("post_rst_d0_seg", {25'd0, seg_outputs}, 32'h40);
    repeat (2 * FRAME) tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = $urandom;
      wr_mask  = 8'($urandom);
      wr_dp    = 8'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
      tick();
    end
    wr_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
